prs_counter_bank: RTL and testbench

PRS_COUNTER_BANK -- requirements
Module: prs_counter_bank

---
 rtl/prs_pkg.sv | 25 ++
 rtl/prs_channel.sv | 90 +++++++++
 rtl/prs_counter_bank.sv | 129 ++++++++++++
 tb/tb_prs_counter_bank.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prs_pkg.sv
// Shared definitions for the pulse counter bank.
// Holds the command opcodes, the capture FSM state encodings and the
// EDGE_MODE selector values used by prs_counter_bank and prs_channel.
package prs_pkg;

  // Command opcodes carried on i_cmd_op.
  typedef enum logic [1:0] {
    OpNop       = 2'b00,
    OpSnap      = 2'b01,
    OpSnapClear = 2'b10,
    OpSetEn     = 2'b11
  } cmd_op_e;

  // Capture FSM. The two spare encodings are unreachable and decode to StIdle.
  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StWaitAck = 2'b01
  } state_e;

  // EDGE_MODE values: which synchronised input transition counts as an event.
  localparam int unsigned EdgeRise = 0;
  localparam int unsigned EdgeFall = 1;
  localparam int unsigned EdgeBoth = 2;

endpackage

// File: rtl/prs_channel.sv
// One pulse-counting channel: input synchroniser, edge detector, counter and
// sticky overflow flag.
//
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_ch           : asynchronous pulse input
//   i_en           : channel enable; edge pulses are dropped while low
//   i_clear        : load counter with this cycle's enabled pulse (0 or 1), clear ovf
//   o_cnt          : current count
//   o_ovf          : sticky overflow flag
module prs_channel
  import prs_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SATURATE    = 1,
  parameter int unsigned EDGE_MODE   = EdgeRise
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ch,
  input  logic             i_en,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   cur;
  logic                   pulse;
  logic                   cnt_inc;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_ch};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cur = sync_q[SYNC_STAGES-1];

  // Single-cycle event pulse derived from the last sync stage and history flop.
  always_comb begin
    pulse = cur & ~hist_q;
    if (EDGE_MODE == EdgeFall) begin
      pulse = ~cur & hist_q;
    end else if (EDGE_MODE == EdgeBoth) begin
      pulse = cur ^ hist_q;
    end
  end

  assign cnt_inc = pulse & i_en;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (i_clear) begin
      // The event arriving on the clear edge belongs to the new interval.
      cnt_d = {{(CNT_W-1){1'b0}}, cnt_inc};
      ovf_d = 1'b0;
    end else if (cnt_inc) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = (SATURATE != 0) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_cnt = cnt_q;
  assign o_ovf = ovf_q;

endmodule

// File: rtl/prs_counter_bank.sv
// Bank of NUM_CH pulse counters with a command port for enable control and
// atomic snapshot (optionally with clear) of all counts and overflow flags.
//
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_ch           : asynchronous pulse inputs, one per channel
//   i_cmd_valid    : command request; accepted when o_cmd_ready is high
//   i_cmd_op       : NOP / SNAP / SNAP_CLEAR / SET_EN
//   i_cmd_data     : new enable mask for SET_EN
//   o_cmd_ready    : high only while idle and out of reset
//   o_snap_data    : captured counts, channel k at [k*CNT_W +: CNT_W]
//   o_snap_ovf     : captured overflow flags
//   o_snap_valid   : snapshot held, waiting for i_snap_ack
//   i_snap_ack     : host has consumed the snapshot
//   o_en_mask      : current channel enable mask
module prs_counter_bank
  import prs_pkg::*;
#(
  parameter int unsigned       NUM_CH        = 16,
  parameter int unsigned       CNT_W         = 8,
  parameter int unsigned       SYNC_STAGES   = 2,
  parameter int unsigned       SATURATE      = 1,
  parameter int unsigned       EDGE_MODE     = EdgeRise,
  parameter logic [NUM_CH-1:0] RESET_EN_MASK = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_CH-1:0]       i_ch,
  input  logic                    i_cmd_valid,
  input  logic [1:0]              i_cmd_op,
  input  logic [NUM_CH-1:0]       i_cmd_data,
  output logic                    o_cmd_ready,
  output logic [NUM_CH*CNT_W-1:0] o_snap_data,
  output logic [NUM_CH-1:0]       o_snap_ovf,
  output logic                    o_snap_valid,
  input  logic                    i_snap_ack,
  output logic [NUM_CH-1:0]       o_en_mask
);

  state_e                  state_q, state_d;
  cmd_op_e                 op;
  logic [NUM_CH-1:0]       en_q, en_d;
  logic [NUM_CH*CNT_W-1:0] cnt_all;
  logic [NUM_CH-1:0]       ovf_all;
  logic [NUM_CH*CNT_W-1:0] snap_data_q, snap_data_d;
  logic [NUM_CH-1:0]       snap_ovf_q, snap_ovf_d;
  logic                    accept;
  logic                    capture;
  logic                    clear;

  assign op = cmd_op_e'(i_cmd_op);

  // Gated by i_rst_n so the host never sees ready while reset is held.
  assign o_cmd_ready = i_rst_n && (state_q == StIdle);
  assign accept      = i_cmd_valid && o_cmd_ready;

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    snap_data_d = snap_data_q;
    snap_ovf_d  = snap_ovf_q;
    capture     = 1'b0;
    clear       = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (op)
            OpNop:       ;
            OpSetEn:     en_d = i_cmd_data;
            OpSnap:      capture = 1'b1;
            OpSnapClear: begin
              capture = 1'b1;
              clear   = 1'b1;
            end
          endcase
        end
      end
      StWaitAck: begin
        if (i_snap_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Counters report their pre-edge values, so capture and clear share one edge.
    if (capture) begin
      snap_data_d = cnt_all;
      snap_ovf_d  = ovf_all;
      state_d     = StWaitAck;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      en_q        <= RESET_EN_MASK;
      snap_data_q <= '0;
      snap_ovf_q  <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      snap_data_q <= snap_data_d;
      snap_ovf_q  <= snap_ovf_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    prs_channel #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .SATURATE    (SATURATE),
      .EDGE_MODE   (EDGE_MODE)
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_ch    (i_ch[k]),
      .i_en    (en_q[k]),
      .i_clear (clear),
      .o_cnt   (cnt_all[k*CNT_W +: CNT_W]),
      .o_ovf   (ovf_all[k])
    );
  end

  assign o_snap_data  = snap_data_q;
  assign o_snap_ovf   = snap_ovf_q;
  assign o_snap_valid = (state_q == StWaitAck);
  assign o_en_mask    = en_q;

endmodule

// File: tb/tb_prs_counter_bank.sv
// Directed bench for prs_counter_bank. Four instances share all inputs:
//   dut0 SATURATE=1 rising, dut1 SATURATE=0 both edges,
//   dut2 SATURATE=1 falling (reset mask A5A5), dut3 SATURATE=0 rising (reset mask 0F0F).
module tb_prs_counter_bank;
  import prs_pkg::*;

  localparam int unsigned NCH  = 16;
  localparam int unsigned CW   = 8;
  localparam int          NDUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [NCH-1:0] ch;
  logic           cmd_valid;
  logic [1:0]     cmd_op;
  logic [NCH-1:0] cmd_data;
  logic           snap_ack;

  logic              rdy    [NDUT];
  logic [NCH*CW-1:0] sdata  [NDUT];
  logic [NCH-1:0]    sovf   [NDUT];
  logic              svalid [NDUT];
  logic [NCH-1:0]    enm    [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    prs_counter_bank #(
      .NUM_CH        (NCH),
      .CNT_W         (CW),
      .SYNC_STAGES   (2),
      .SATURATE      ((g == 1 || g == 3) ? 0 : 1),
      .EDGE_MODE     ((g == 1) ? EdgeBoth : (g == 2) ? EdgeFall : EdgeRise),
      .RESET_EN_MASK ((g == 2) ? 16'hA5A5 : (g == 3) ? 16'h0F0F : 16'h0000)
    ) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_ch         (ch),
      .i_cmd_valid  (cmd_valid),
      .i_cmd_op     (cmd_op),
      .i_cmd_data   (cmd_data),
      .o_cmd_ready  (rdy[g]),
      .o_snap_data  (sdata[g]),
      .o_snap_ovf   (sovf[g]),
      .o_snap_valid (svalid[g]),
      .i_snap_ack   (snap_ack),
      .o_en_mask    (enm[g])
    );
  end

  int total = 0;
  int bad   = 0;

  function automatic int unsigned rst_mask(input int g);
    case (g)
      2:       return 32'h0000_A5A5;
      3:       return 32'h0000_0F0F;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag, input int c,
                         input int unsigned ea, input int unsigned eb,
                         input int unsigned ec, input int unsigned ed);
    int unsigned ex [NDUT];
    ex[0] = ea; ex[1] = eb; ex[2] = ec; ex[3] = ed;
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("%s_cnt_ch%0d_dut%0d", tag, c, g), 32'(sdata[g][c*CW +: CW]), ex[g]);
  endtask

  task automatic chk_ovf(input string tag, input int c,
                         input int unsigned ea, input int unsigned eb,
                         input int unsigned ec, input int unsigned ed);
    int unsigned ex [NDUT];
    ex[0] = ea; ex[1] = eb; ex[2] = ec; ex[3] = ed;
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("%s_ovf_ch%0d_dut%0d", tag, c, g), 32'(sovf[g][c]), ex[g]);
  endtask

  // Called at a negedge; presents the command for exactly one posedge.
  task automatic issue(input logic [1:0] op, input logic [NCH-1:0] data, input string tag);
    for (int g = 0; g < NDUT; g++) chk($sformatf("%s_ready_dut%0d", tag, g), 32'(rdy[g]), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = OpNop;
    for (int g = 0; g < NDUT; g++) begin
      if (op == OpSnap || op == OpSnapClear) begin
        chk($sformatf("%s_valid_dut%0d", tag, g), 32'(svalid[g]), 1);
      end else begin
        chk($sformatf("%s_valid_dut%0d", tag, g), 32'(svalid[g]), 0);
        chk($sformatf("%s_enmask_dut%0d", tag, g), 32'(enm[g]), 32'(data));
      end
    end
  endtask

  task automatic ack(input string tag);
    repeat (2) begin
      for (int g = 0; g < NDUT; g++) begin
        chk($sformatf("%s_wait_ready_dut%0d", tag, g), 32'(rdy[g]), 0);
        chk($sformatf("%s_wait_valid_dut%0d", tag, g), 32'(svalid[g]), 1);
      end
      @(negedge clk);
    end
    snap_ack = 1'b1;
    @(negedge clk);
    snap_ack = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("%s_acked_valid_dut%0d", tag, g), 32'(svalid[g]), 0);
      chk($sformatf("%s_acked_ready_dut%0d", tag, g), 32'(rdy[g]), 1);
    end
  endtask

  // n full pulses (3 cycles high, 3 low) on the channels in pat, then settle.
  task automatic pulse(input logic [NCH-1:0] pat, input int n);
    repeat (n) begin
      ch = ch | pat;
      cyc(3);
      ch = ch & ~pat;
      cyc(3);
    end
    cyc(4);
  endtask

  typedef struct {
    logic [NCH-1:0] en;
    logic [NCH-1:0] pat;
    int             n;
    int             c;
    int             zc;
    int unsigned    ea, eb, ec, ed;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{16'h0001, 16'h0003, 5, 0, 1, 5, 10, 5, 5};
    vecs[1] = '{16'h0008, 16'h0028, 4, 3, 5, 4, 8, 4, 4};
    vecs[2] = '{16'hFFFF, 16'h8000, 3, 15, 14, 3, 6, 3, 3};
    vecs[3] = '{16'h0000, 16'hFFFF, 2, 7, 0, 0, 0, 0, 0};
    vecs[4] = '{16'h0100, 16'h0300, 1, 8, 9, 1, 2, 1, 1};

    rst_n = 1'b0; ch = '0; cmd_valid = 1'b0; cmd_op = OpNop; cmd_data = '0; snap_ack = 1'b0;
    cyc(3);
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("rst_ready_dut%0d", g), 32'(rdy[g]), 0);
      chk($sformatf("rst_valid_dut%0d", g), 32'(svalid[g]), 0);
      chk($sformatf("rst_enmask_dut%0d", g), 32'(enm[g]), rst_mask(g));
      chk($sformatf("rst_sdata_dut%0d", g), 32'(|sdata[g]), 0);
      chk($sformatf("rst_sovf_dut%0d", g), 32'(sovf[g]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) chk($sformatf("post_rst_ready_dut%0d", g), 32'(rdy[g]), 1);

    // Table: enable, pulse, snapshot, check one counted and one idle channel.
    for (int i = 0; i < 5; i++) begin
      issue(OpSetEn, vecs[i].en, $sformatf("vec%0d_seten", i));
      issue(OpSnapClear, '0, $sformatf("vec%0d_drain", i));
      ack($sformatf("vec%0d_drain", i));
      pulse(vecs[i].pat, vecs[i].n);
      issue(OpSnap, '0, $sformatf("vec%0d_snap", i));
      chk_cnt($sformatf("vec%0d", i), vecs[i].c, vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ed);
      chk_cnt($sformatf("vec%0d_idle", i), vecs[i].zc, 0, 0, 0, 0);
      ack($sformatf("vec%0d_snap", i));
    end

    // 300 pulses: saturate at 255 or wrap (300-256=44, both-edge 600-512=88).
    issue(OpSetEn, 16'h0001, "sat_seten");
    issue(OpSnapClear, '0, "sat_drain");
    ack("sat_drain");
    pulse(16'h0001, 300);
    issue(OpSnap, '0, "sat_snap");
    chk_cnt("sat", 0, 255, 88, 255, 44);
    chk_ovf("sat", 0, 1, 1, 1, 1);
    ack("sat_snap");
    issue(OpSnapClear, '0, "sat_clr");
    chk_cnt("sat_clr", 0, 255, 88, 255, 44);
    chk_ovf("sat_clr", 0, 1, 1, 1, 1);
    ack("sat_clr");

    // SNAP_CLEAR on the same edge as a rising event on ch0.
    pulse(16'h0001, 7);
    ch[0] = 1'b1;
    cyc(2);
    issue(OpSnapClear, '0, "edge_clr");
    chk_cnt("edge_clr", 0, 7, 14, 7, 7);
    chk_ovf("edge_clr", 0, 0, 0, 0, 0);
    ack("edge_clr");
    ch[0] = 1'b0;
    cyc(4);
    issue(OpSnap, '0, "edge_after");
    chk_cnt("edge_after", 0, 1, 2, 1, 1);
    chk_ovf("edge_after", 0, 0, 0, 0, 0);
    ack("edge_after");

    // Ack presented while idle, together with an accepted SNAP_CLEAR.
    cmd_valid = 1'b1; cmd_op = OpSnapClear; snap_ack = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = OpNop; snap_ack = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) chk($sformatf("idle_ack_valid_dut%0d", g), 32'(svalid[g]), 1);
    chk_cnt("idle_ack", 0, 1, 2, 1, 1);
    ack("idle_ack");

    // SNAP held valid through WAIT_ACK while ch0 keeps toggling.
    cmd_valid = 1'b1; cmd_op = OpSnap;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) chk($sformatf("hold_valid_dut%0d", g), 32'(svalid[g]), 1);
    for (int i = 0; i < 15; i++) begin
      ch[0] = (i < 10) && ((i % 4) < 2);
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        chk($sformatf("hold%0d_ready_dut%0d", i, g), 32'(rdy[g]), 0);
        chk($sformatf("hold%0d_valid_dut%0d", i, g), 32'(svalid[g]), 1);
        chk($sformatf("hold%0d_cnt_dut%0d", i, g), 32'(sdata[g][0 +: CW]), 0);
      end
    end
    snap_ack = 1'b1;
    @(negedge clk);
    snap_ack = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("hold_ret_valid_dut%0d", g), 32'(svalid[g]), 0);
      chk($sformatf("hold_ret_ready_dut%0d", g), 32'(rdy[g]), 1);
    end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = OpNop;
    for (int g = 0; g < NDUT; g++) chk($sformatf("hold_again_valid_dut%0d", g), 32'(svalid[g]), 1);
    chk_cnt("hold_again", 0, 3, 6, 3, 3);

    // Reset while a snapshot is pending.
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("mid_rst_valid_dut%0d", g), 32'(svalid[g]), 0);
      chk($sformatf("mid_rst_ready_dut%0d", g), 32'(rdy[g]), 0);
      chk($sformatf("mid_rst_enmask_dut%0d", g), 32'(enm[g]), rst_mask(g));
      chk($sformatf("mid_rst_sdata_dut%0d", g), 32'(|sdata[g]), 0);
    end
    cyc(2);
    rst_n = 1'b1;
    @(negedge clk);
    issue(OpSnap, '0, "post_rst_snap");
    chk_cnt("post_rst", 0, 0, 0, 0, 0);
    chk_ovf("post_rst", 0, 0, 0, 0, 0);
    ack("post_rst_snap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
